// File: rtl/rs_pkg.sv
// Shared definitions for the reservation-station slice.
// Tags are laid out as {station id, entry index}; the all-zero tag (TAG_NONE)
// means "operand value already present", which is why station ids are nonzero.
// Contents: tag constants, opcode encodings, lock-state enum, tag builder.
package rs_pkg;

   // Widest tag the helper function can build; callers size-cast the result.
   localparam int TAG_MAX_W = 16;

   localparam logic [TAG_MAX_W-1:0] TAG_NONE = '0;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_AND = 2'd2,
      OP_OR  = 2'd3
   } rsOp_e;

   // Whether the issue port is currently pinned to one entry.
   typedef enum logic {
      LOCK_FREE = 1'b0,
      LOCK_HELD = 1'b1
   } lockState_e;

   // Build {sid, idx} with idx occupying the low idxW bits.
   function automatic logic [TAG_MAX_W-1:0] buildTag(input int unsigned sid,
                                                      input int unsigned idx,
                                                      input int unsigned idxW);
      logic [TAG_MAX_W-1:0] sidBits;
      logic [TAG_MAX_W-1:0] idxBits;
      sidBits = TAG_MAX_W'(sid);
      idxBits = TAG_MAX_W'(idx);
      return (sidBits << idxW) | idxBits;
   endfunction

endpackage

// File: rtl/rs_age_select.sv
// Oldest-ready picker for the reservation station.
// Purely combinational: given which entries are ready and the age matrix
// (older[i][j]=1 means i was allocated before j), returns the single ready
// entry that has no older ready entry.
// Ports:
//   ready  - per-entry ready flags
//   older  - DEPTH x DEPTH age matrix
//   oneHot - one-hot of the selected entry (zero when nothing is ready)
//   idx    - binary index of the selected entry
//   valid  - some entry is selected
module rs_age_select
   import rs_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int IDX_W = 2
)(
   input  logic [DEPTH-1:0]            ready,
   input  logic [DEPTH-1:0][DEPTH-1:0] older,
   output logic [DEPTH-1:0]            oneHot,
   output logic [IDX_W-1:0]            idx,
   output logic                        valid
);

   logic [DEPTH-1:0] blocker;

   // An entry is blocked when any ready entry was allocated before it. Among
   // busy entries the age relation is a total order, so at most one ready
   // entry survives.
   always_comb begin
      blocker = '0;
      for (int i = 0; i < DEPTH; i++) begin
         for (int j = 0; j < DEPTH; j++) begin
            if (ready[j] && older[j][i]) begin
               blocker[i] = 1'b1;
            end
         end
      end
   end

   // Encode the surviving entry; the one-hot guarantees a single match.
   always_comb begin
      oneHot = ready & ~blocker;
      idx    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (oneHot[i]) begin
            idx = IDX_W'(i);
         end
      end
   end

   assign valid = |oneHot;

endmodule

// File: rtl/rs_station_ooo.sv
// Reservation station for one functional-unit class of the Tomasulo core.
// Holds up to DEPTH waiting instructions, captures operands from the CDB,
// and issues the oldest ready entry over a valid/ready handshake. Once the
// issue port presents an entry it stays pinned there until accepted.
// Ports:
//   clk, nRST          - clock, synchronous active-low reset
//   flush              - drop every entry
//   alloc_*            - new instruction (operand value valid when its q is 0)
//   alloc_tag          - tag the next allocation will receive
//   full, count        - occupancy from registered state
//   bc_en/bc_tag/bc_data - CDB broadcast
//   issue_*            - issue port to the execution unit
module rs_station_ooo
   import rs_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int DATA_W     = 32,
   parameter int OP_W       = 2,
   parameter int IDX_W      = 2,
   parameter int SID_W      = 2,
   parameter int TAG_W      = SID_W + IDX_W,
   parameter int STATION_ID = 1
)(
   input  logic              clk,
   input  logic              nRST,
   input  logic              flush,
   input  logic              alloc_en,
   input  logic [OP_W-1:0]   alloc_op,
   input  logic [DATA_W-1:0] alloc_v1,
   input  logic [DATA_W-1:0] alloc_v2,
   input  logic [TAG_W-1:0]  alloc_q1,
   input  logic [TAG_W-1:0]  alloc_q2,
   output logic [TAG_W-1:0]  alloc_tag,
   output logic              full,
   output logic [IDX_W:0]    count,
   input  logic              bc_en,
   input  logic [TAG_W-1:0]  bc_tag,
   input  logic [DATA_W-1:0] bc_data,
   output logic              issue_valid,
   input  logic              issue_ready,
   output logic [OP_W-1:0]   issue_op,
   output logic [DATA_W-1:0] issue_v1,
   output logic [DATA_W-1:0] issue_v2,
   output logic [TAG_W-1:0]  issue_tag
);

   localparam logic [TAG_W-1:0] NoTag = TAG_W'(TAG_NONE);

   logic [DEPTH-1:0]            busy;
   logic [DEPTH-1:0]            busyNext;
   logic [DEPTH-1:0][DEPTH-1:0] older;
   logic [OP_W-1:0]             opArr [DEPTH];
   logic [DATA_W-1:0]           vjArr [DEPTH];
   logic [DATA_W-1:0]           vkArr [DEPTH];
   logic [TAG_W-1:0]            qjArr [DEPTH];
   logic [TAG_W-1:0]            qkArr [DEPTH];

   logic [DEPTH-1:0] readyVec;
   logic [DEPTH-1:0] ageOneHot;
   logic [IDX_W-1:0] ageIdx;
   logic             ageValid;
   logic [DEPTH-1:0] issueMask;

   lockState_e       lockState;
   lockState_e       lockNext;
   logic [IDX_W-1:0] lockIdx;
   logic [IDX_W-1:0] lockIdxNext;
   logic [IDX_W-1:0] selIdx;

   logic [IDX_W-1:0] freeIdx;
   logic [IDX_W:0]   busyCount;
   logic             doAlloc;
   logic             doIssue;
   logic             bcLive;

   // Occupancy, lowest free slot and readiness all come from registered
   // state, so a slot freed by issue this cycle is only reusable next cycle.
   always_comb begin
      freeIdx   = '0;
      busyCount = '0;
      readyVec  = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            freeIdx = IDX_W'(i);
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         busyCount   = busyCount + (IDX_W+1)'(busy[i]);
         readyVec[i] = busy[i] && (qjArr[i] == NoTag) && (qkArr[i] == NoTag);
      end
   end

   rs_age_select #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) ageSelect (
      .ready  (readyVec),
      .older  (older),
      .oneHot (ageOneHot),
      .idx    (ageIdx),
      .valid  (ageValid)
   );

   assign full        = (busyCount == (IDX_W+1)'(DEPTH));
   assign count       = busyCount;
   assign doAlloc     = alloc_en && !full;
   assign bcLive      = bc_en && (bc_tag != NoTag);
   assign selIdx      = (lockState == LOCK_HELD) ? lockIdx : ageIdx;
   assign issue_valid = (lockState == LOCK_HELD) || ageValid;
   assign doIssue     = issue_valid && issue_ready;

   assign alloc_tag = TAG_W'(buildTag(STATION_ID, 32'(freeIdx), IDX_W));
   assign issue_tag = TAG_W'(buildTag(STATION_ID, 32'(selIdx), IDX_W));
   assign issue_op  = opArr[selIdx];
   assign issue_v1  = vjArr[selIdx];
   assign issue_v2  = vkArr[selIdx];

   // The entry leaving on a handshake is the pinned one if a lock is held,
   // otherwise whatever the age picker chose; the allocated slot is free in
   // registered state, so it can never collide with the issued one.
   always_comb begin
      issueMask = ageOneHot;
      if (lockState == LOCK_HELD) begin
         issueMask          = '0;
         issueMask[lockIdx] = 1'b1;
      end
      busyNext = busy;
      if (doIssue) begin
         busyNext = busyNext & ~issueMask;
      end
      if (doAlloc) begin
         busyNext[freeIdx] = 1'b1;
      end
   end

   // Pin the presented entry as soon as it is offered without acceptance so
   // a newly woken older entry cannot displace it mid-handshake.
   always_comb begin
      lockNext    = lockState;
      lockIdxNext = lockIdx;
      if (doIssue) begin
         lockNext = LOCK_FREE;
      end else if (issue_valid) begin
         lockNext    = LOCK_HELD;
         lockIdxNext = selIdx;
      end
   end

   always_ff @(posedge clk) begin
      if (!nRST || flush) begin
         lockState <= LOCK_FREE;
         lockIdx   <= '0;
      end else begin
         lockState <= lockNext;
         lockIdx   <= lockIdxNext;
      end
   end

   // Busy flags and age matrix. A new entry is younger than everything
   // currently busy; its own row is cleared because nothing is younger yet.
   always_ff @(posedge clk) begin
      if (!nRST || flush) begin
         busy  <= '0;
         older <= '0;
      end else begin
         busy <= busyNext;
         if (doAlloc) begin
            for (int i = 0; i < DEPTH; i++) begin
               for (int j = 0; j < DEPTH; j++) begin
                  if (freeIdx == IDX_W'(i)) begin
                     older[i][j] <= 1'b0;
                  end else if (freeIdx == IDX_W'(j)) begin
                     older[i][j] <= busy[i];
                  end
               end
            end
         end
      end
   end

   // Entry payload. Needs no reset because busy gates every use. A new entry
   // takes a same-cycle broadcast of its producer tag directly, otherwise
   // busy entries waiting on the broadcast tag capture the value.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (doAlloc && (freeIdx == IDX_W'(i))) begin
            opArr[i] <= alloc_op;
            if (bcLive && (bc_tag == alloc_q1)) begin
               vjArr[i] <= bc_data;
               qjArr[i] <= NoTag;
            end else begin
               vjArr[i] <= alloc_v1;
               qjArr[i] <= alloc_q1;
            end
            if (bcLive && (bc_tag == alloc_q2)) begin
               vkArr[i] <= bc_data;
               qkArr[i] <= NoTag;
            end else begin
               vkArr[i] <= alloc_v2;
               qkArr[i] <= alloc_q2;
            end
         end else if (busy[i] && bcLive) begin
            if (qjArr[i] == bc_tag) begin
               vjArr[i] <= bc_data;
               qjArr[i] <= NoTag;
            end
            if (qkArr[i] == bc_tag) begin
               vkArr[i] <= bc_data;
               qkArr[i] <= NoTag;
            end
         end
      end
   end

endmodule

// File: tb/tb_rs_station_ooo.sv
// Self-checking bench for rs_station_ooo: directed scenarios followed by
// randomized traffic, all compared each cycle against a sequence-number
// based reference model of the station.
module tb_rs_station_ooo;
   import rs_pkg::*;

   localparam int DEPTH      = 4;
   localparam int DATA_W     = 32;
   localparam int OP_W       = 2;
   localparam int IDX_W      = 2;
   localparam int SID_W      = 2;
   localparam int TAG_W      = SID_W + IDX_W;
   localparam int STATION_ID = 1;

   logic              clk = 1'b0;
   logic              nRST;
   logic              flush;
   logic              alloc_en;
   logic [OP_W-1:0]   alloc_op;
   logic [DATA_W-1:0] alloc_v1;
   logic [DATA_W-1:0] alloc_v2;
   logic [TAG_W-1:0]  alloc_q1;
   logic [TAG_W-1:0]  alloc_q2;
   logic [TAG_W-1:0]  alloc_tag;
   logic              full;
   logic [IDX_W:0]    count;
   logic              bc_en;
   logic [TAG_W-1:0]  bc_tag;
   logic [DATA_W-1:0] bc_data;
   logic              issue_valid;
   logic              issue_ready;
   logic [OP_W-1:0]   issue_op;
   logic [DATA_W-1:0] issue_v1;
   logic [DATA_W-1:0] issue_v2;
   logic [TAG_W-1:0]  issue_tag;

   int checks = 0;
   int errors = 0;

   // Reference model: each entry remembers an allocation sequence number;
   // the oldest ready entry is simply the smallest sequence number.
   bit          mBusy [DEPTH];
   logic [1:0]  mOp   [DEPTH];
   logic [31:0] mV1   [DEPTH];
   logic [31:0] mV2   [DEPTH];
   logic [3:0]  mQ1   [DEPTH];
   logic [3:0]  mQ2   [DEPTH];
   int          mSeq  [DEPTH];
   int          seqCtr = 0;
   bit          mLocked = 1'b0;
   int          mLockIdx = 0;
   bit          modelValid = 1'b0;

   rs_station_ooo #(
      .DEPTH      (DEPTH),
      .DATA_W     (DATA_W),
      .OP_W       (OP_W),
      .IDX_W      (IDX_W),
      .SID_W      (SID_W),
      .TAG_W      (TAG_W),
      .STATION_ID (STATION_ID)
   ) dut (
      .clk         (clk),
      .nRST        (nRST),
      .flush       (flush),
      .alloc_en    (alloc_en),
      .alloc_op    (alloc_op),
      .alloc_v1    (alloc_v1),
      .alloc_v2    (alloc_v2),
      .alloc_q1    (alloc_q1),
      .alloc_q2    (alloc_q2),
      .alloc_tag   (alloc_tag),
      .full        (full),
      .count       (count),
      .bc_en       (bc_en),
      .bc_tag      (bc_tag),
      .bc_data     (bc_data),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_op    (issue_op),
      .issue_v1    (issue_v1),
      .issue_v2    (issue_v2),
      .issue_tag   (issue_tag)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int modelSel();
      int best;
      best = -1;
      if (mLocked) return mLockIdx;
      for (int i = 0; i < DEPTH; i++) begin
         if (mBusy[i] && mQ1[i] == 4'd0 && mQ2[i] == 4'd0 && (best < 0 || mSeq[i] < mSeq[best]))
            best = i;
      end
      return best;
   endfunction

   function automatic int modelCount();
      int n;
      n = 0;
      for (int i = 0; i < DEPTH; i++) if (mBusy[i]) n++;
      return n;
   endfunction

   function automatic int modelFree();
      for (int i = 0; i < DEPTH; i++) if (!mBusy[i]) return i;
      return -1;
   endfunction

   function automatic logic [31:0] expTag(input int idx);
      return 32'(STATION_ID * (1 << IDX_W) + idx);
   endfunction

   task automatic modelCheck();
      int sel;
      int cnt;
      if (!modelValid) return;
      sel = modelSel();
      cnt = modelCount();
      checkOutput("issueValid", 32'(issue_valid), (sel >= 0) ? 32'd1 : 32'd0);
      if (sel >= 0) begin
         checkOutput("issueOp", 32'(issue_op), 32'(mOp[sel]));
         checkOutput("issueV1", issue_v1, mV1[sel]);
         checkOutput("issueV2", issue_v2, mV2[sel]);
         checkOutput("issueTag", 32'(issue_tag), expTag(sel));
      end
      checkOutput("count", 32'(count), 32'(cnt));
      checkOutput("full", 32'(full), (cnt == DEPTH) ? 32'd1 : 32'd0);
      if (cnt != DEPTH) checkOutput("allocTag", 32'(alloc_tag), expTag(modelFree()));
   endtask

   task automatic modelUpdate();
      int sel;
      int k;
      bit fireIssue;
      if (!nRST || flush) begin
         for (int i = 0; i < DEPTH; i++) mBusy[i] = 1'b0;
         mLocked = 1'b0;
         if (!nRST) modelValid = 1'b1;
         return;
      end
      if (!modelValid) return;
      sel = modelSel();
      k = modelFree();
      fireIssue = (sel >= 0) && issue_ready;
      if (bc_en && bc_tag != 4'd0) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (mBusy[i] && mQ1[i] == bc_tag) begin mV1[i] = bc_data; mQ1[i] = 4'd0; end
            if (mBusy[i] && mQ2[i] == bc_tag) begin mV2[i] = bc_data; mQ2[i] = 4'd0; end
         end
      end
      if (fireIssue) begin
         mBusy[sel] = 1'b0;
         mLocked = 1'b0;
      end else if (sel >= 0) begin
         mLocked = 1'b1;
         mLockIdx = sel;
      end
      if (alloc_en && k >= 0) begin
         mBusy[k] = 1'b1;
         mOp[k] = alloc_op;
         mSeq[k] = seqCtr++;
         if (bc_en && alloc_q1 != 4'd0 && bc_tag == alloc_q1) begin mV1[k] = bc_data; mQ1[k] = 4'd0; end
         else begin mV1[k] = alloc_v1; mQ1[k] = alloc_q1; end
         if (bc_en && alloc_q2 != 4'd0 && bc_tag == alloc_q2) begin mV2[k] = bc_data; mQ2[k] = 4'd0; end
         else begin mV2[k] = alloc_v2; mQ2[k] = alloc_q2; end
      end
   endtask

   // One clock: compare against the model, take the edge, advance the model,
   // then drop the single-cycle request inputs.
   task automatic applyStimulus();
      #1;
      modelCheck();
      @(posedge clk);
      modelUpdate();
      @(negedge clk);
      alloc_en = 1'b0;
      bc_en    = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic setAlloc(input logic [1:0] op, input logic [31:0] v1, input logic [31:0] v2,
                           input logic [3:0] q1, input logic [3:0] q2);
      alloc_en = 1'b1;
      alloc_op = op;
      alloc_v1 = v1;
      alloc_v2 = v2;
      alloc_q1 = q1;
      alloc_q2 = q2;
   endtask

   task automatic setBc(input logic [3:0] tag, input logic [31:0] data);
      bc_en   = 1'b1;
      bc_tag  = tag;
      bc_data = data;
   endtask

   function automatic logic [3:0] pickTag();
      case ($urandom_range(0, 6))
         0: return 4'd5;
         1: return 4'd6;
         2: return 4'd9;
         3: return 4'd12;
         default: return 4'd0;
      endcase
   endfunction

   initial begin
      nRST = 1'b0; flush = 1'b0; alloc_en = 1'b0; alloc_op = '0;
      alloc_v1 = '0; alloc_v2 = '0; alloc_q1 = '0; alloc_q2 = '0;
      bc_en = 1'b0; bc_tag = '0; bc_data = '0; issue_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) mBusy[i] = 1'b0;
      @(negedge clk);

      // Reset state
      applyStimulus();
      applyStimulus();
      nRST = 1'b1;
      checkOutput("rstValid", 32'(issue_valid), 32'd0);
      checkOutput("rstCount", 32'(count), 32'd0);
      checkOutput("rstFull", 32'(full), 32'd0);
      checkOutput("rstAllocTag", 32'(alloc_tag), 32'd4);

      // Fill the station, try one more allocation while full
      for (int k = 1; k <= 4; k++) begin
         setAlloc(2'(k - 1), 32'(k), 32'(k * 2), 4'd0, 4'd0);
         applyStimulus();
      end
      checkOutput("fillFull", 32'(full), 32'd1);
      checkOutput("fillCount", 32'(count), 32'd4);
      setAlloc(OP_OR, 32'd99, 32'd99, 4'd0, 4'd0);
      applyStimulus();
      checkOutput("fullIgnored", 32'(count), 32'd4);

      // Drain in allocation order
      issue_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         checkOutput("orderV1", issue_v1, 32'(k + 1));
         checkOutput("orderTag", 32'(issue_tag), 32'(4 + k));
         applyStimulus();
         if (k == 0) begin
            checkOutput("freedFull", 32'(full), 32'd0);
            checkOutput("freedTag", 32'(alloc_tag), 32'd4);
         end
      end
      checkOutput("drainCount", 32'(count), 32'd0);
      issue_ready = 1'b0;

      // Same-cycle broadcast bypass at allocation
      setAlloc(OP_SUB, 32'd0, 32'd3, 4'd5, 4'd0);
      setBc(4'd5, 32'hAA);
      applyStimulus();
      checkOutput("bypassValid", 32'(issue_valid), 32'd1);
      checkOutput("bypassV1", issue_v1, 32'hAA);
      issue_ready = 1'b1;
      applyStimulus();
      issue_ready = 1'b0;
      checkOutput("bypassDone", 32'(count), 32'd0);

      // Lock: younger ready entry stays on the port when an older one wakes
      setAlloc(OP_ADD, 32'd11, 32'd0, 4'd0, 4'd0);
      applyStimulus();
      setAlloc(OP_ADD, 32'd0, 32'd0, 4'd9, 4'd0);
      applyStimulus();
      setAlloc(OP_AND, 32'd0, 32'd33, 4'd6, 4'd0);
      applyStimulus();
      issue_ready = 1'b1;
      checkOutput("lockFirstTag", 32'(issue_tag), 32'd4);
      applyStimulus();
      issue_ready = 1'b0;
      setAlloc(OP_OR, 32'd44, 32'd0, 4'd0, 4'd0);
      applyStimulus();
      checkOutput("lockBTag", 32'(issue_tag), 32'd4);
      applyStimulus();
      setBc(4'd6, 32'h66);
      applyStimulus();
      checkOutput("lockHeldTag", 32'(issue_tag), 32'd4);
      checkOutput("lockHeldV1", issue_v1, 32'd44);
      issue_ready = 1'b1;
      applyStimulus();
      checkOutput("lockNextTag", 32'(issue_tag), 32'd6);
      checkOutput("lockNextV1", issue_v1, 32'h66);
      applyStimulus();
      issue_ready = 1'b0;
      setBc(4'd9, 32'h77);
      applyStimulus();
      checkOutput("lastTag", 32'(issue_tag), 32'd5);
      checkOutput("lastV1", issue_v1, 32'h77);
      issue_ready = 1'b1;
      applyStimulus();
      issue_ready = 1'b0;
      checkOutput("lockDone", 32'(count), 32'd0);

      // Flush overrides a same-cycle allocation
      setAlloc(OP_ADD, 32'd1, 32'd1, 4'd0, 4'd0);
      applyStimulus();
      setAlloc(OP_ADD, 32'd2, 32'd2, 4'd12, 4'd0);
      applyStimulus();
      checkOutput("preFlushCount", 32'(count), 32'd2);
      setAlloc(OP_ADD, 32'd3, 32'd3, 4'd0, 4'd0);
      flush = 1'b1;
      applyStimulus();
      checkOutput("flushCount", 32'(count), 32'd0);
      checkOutput("flushValid", 32'(issue_valid), 32'd0);

      // Reset in the middle of a handshake
      setAlloc(OP_SUB, 32'd8, 32'd9, 4'd0, 4'd0);
      applyStimulus();
      issue_ready = 1'b1;
      checkOutput("preRstValid", 32'(issue_valid), 32'd1);
      nRST = 1'b0;
      applyStimulus();
      nRST = 1'b1;
      issue_ready = 1'b0;
      checkOutput("midRstValid", 32'(issue_valid), 32'd0);
      checkOutput("midRstCount", 32'(count), 32'd0);
      checkOutput("midRstFull", 32'(full), 32'd0);
      checkOutput("midRstAllocTag", 32'(alloc_tag), 32'd4);

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         nRST        = ($urandom_range(0, 99) != 0);
         flush       = ($urandom_range(0, 49) == 0);
         alloc_en    = ($urandom_range(0, 1) == 1);
         alloc_op    = 2'($urandom);
         alloc_v1    = $urandom;
         alloc_v2    = $urandom;
         alloc_q1    = pickTag();
         alloc_q2    = pickTag();
         bc_en       = ($urandom_range(0, 2) != 0);
         bc_tag      = pickTag();
         bc_data     = $urandom;
         issue_ready = ($urandom_range(0, 9) < 6);
         applyStimulus();
      end
      nRST = 1'b1;
      issue_ready = 1'b0;
      applyStimulus();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
